// File: rtl/pipe_multi_type_shift.sv
// Pipelined barrel shifter: SRL, SRA, SLL, ROR and ROL over STAGES register stages
// with valid/ready flow control. The log-shift levels are split evenly across the stages.
module pipe_multi_type_shift #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHIFT_WIDTH = 6,
  parameter int unsigned STAGES      = 2
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iVld,
  output logic                   oRdy,
  input  logic [2:0]             iMode,
  input  logic [SHIFT_WIDTH-1:0] iSftBit,
  input  logic [DATA_WIDTH-1:0]  iDat,
  output logic                   oVld,
  input  logic                   iRdy,
  output logic [DATA_WIDTH-1:0]  oDat,
  output logic                   oErr
);

  typedef enum logic [2:0] {
    MODE_SRL = 3'b000,
    MODE_SRA = 3'b001,
    MODE_SLL = 3'b010,
    MODE_ROR = 3'b011,
    MODE_ROL = 3'b100
  } mode_e;

  localparam int unsigned LVL = $clog2(DATA_WIDTH);
  localparam int unsigned PER = (STAGES == 0) ? LVL : (LVL + STAGES - 1) / STAGES;

  if (DATA_WIDTH < 4 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_data_width
    $error("pipe_multi_type_shift: DATA_WIDTH must be a power of 2 and >= 4");
  end
  if (SHIFT_WIDTH < LVL) begin : g_bad_shift_width
    $error("pipe_multi_type_shift: SHIFT_WIDTH must be >= clog2(DATA_WIDTH)");
  end
  if (STAGES < 1 || STAGES > LVL) begin : g_bad_stages
    $error("pipe_multi_type_shift: STAGES must be in 1..clog2(DATA_WIDTH)");
  end

  function automatic logic [DATA_WIDTH-1:0] shift_one(input mode_e m,
                                                       input logic [DATA_WIDTH-1:0] d,
                                                       input int unsigned k);
    case (m)
      MODE_SRL: shift_one = d >> k;
      MODE_SRA: shift_one = $unsigned($signed(d) >>> k);
      MODE_SLL: shift_one = d << k;
      MODE_ROR: shift_one = (d >> k) | (d << (DATA_WIDTH - k));
      MODE_ROL: shift_one = (d << k) | (d >> (DATA_WIDTH - k));
      default:  shift_one = d;
    endcase
  endfunction

  // Applies only the log levels owned by stage s; later stages see the same shift bits.
  function automatic logic [DATA_WIDTH-1:0] apply_stage(input mode_e m,
                                                         input logic [DATA_WIDTH-1:0] d,
                                                         input logic [LVL-1:0] n,
                                                         input int unsigned s);
    logic [DATA_WIDTH-1:0] r;
    int unsigned lo;
    int unsigned hi;
    r  = d;
    lo = s * PER;
    hi = ((s + 1) * PER > LVL) ? LVL : (s + 1) * PER;
    for (int unsigned j = lo; j < hi; j++) begin
      if (n[j]) r = shift_one(m, r, 32'd1 << j);
    end
    return r;
  endfunction

  logic ovr;
  if (SHIFT_WIDTH > LVL) begin : g_ovr
    assign ovr = |iSftBit[SHIFT_WIDTH-1:LVL];
  end else begin : g_no_ovr
    assign ovr = 1'b0;
  end

  logic                  in_err;
  mode_e                 in_mode;
  logic [LVL-1:0]        in_sft;
  logic [DATA_WIDTH-1:0] in_dat;

  // Illegal modes and over-range non-rotates are resolved up front, leaving zero shift bits
  // so the downstream levels pass the data through untouched.
  always_comb begin
    in_err  = 1'b0;
    in_mode = MODE_SRL;
    in_sft  = iSftBit[LVL-1:0];
    in_dat  = iDat;
    case (iMode)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: in_mode = mode_e'(iMode);
      default: begin
        in_err = 1'b1;
        in_sft = '0;
      end
    endcase
    if (!in_err && ovr && (in_mode inside {MODE_SRL, MODE_SRA, MODE_SLL})) begin
      in_sft = '0;
      in_dat = (in_mode == MODE_SRA && iDat[DATA_WIDTH-1]) ? '1 : '0;
    end
  end

  logic [STAGES-1:0]     vld_q, vld_d, err_q, err_d, ld, up_vld, up_err;
  logic [DATA_WIDTH-1:0] dat_q [STAGES];
  logic [DATA_WIDTH-1:0] dat_d [STAGES];
  logic [DATA_WIDTH-1:0] up_dat [STAGES];
  logic [LVL-1:0]        sft_q [STAGES];
  logic [LVL-1:0]        sft_d [STAGES];
  logic [LVL-1:0]        up_sft [STAGES];
  mode_e                 mode_q [STAGES];
  mode_e                 mode_d [STAGES];
  mode_e                 up_mode [STAGES];

  always_comb begin
    // A stage may load when it or any stage downstream of it has a hole, or the sink drains.
    for (int unsigned s = 0; s < STAGES; s++) begin
      ld[s] = iRdy;
      for (int unsigned j = s; j < STAGES; j++) begin
        if (!vld_q[j]) ld[s] = 1'b1;
      end
    end

    up_vld[0]  = iVld;
    up_err[0]  = in_err;
    up_dat[0]  = in_dat;
    up_sft[0]  = in_sft;
    up_mode[0] = in_mode;
    for (int unsigned s = 1; s < STAGES; s++) begin
      up_vld[s]  = vld_q[s-1];
      up_err[s]  = err_q[s-1];
      up_dat[s]  = dat_q[s-1];
      up_sft[s]  = sft_q[s-1];
      up_mode[s] = mode_q[s-1];
    end

    for (int unsigned s = 0; s < STAGES; s++) begin
      vld_d[s]  = vld_q[s];
      err_d[s]  = err_q[s];
      dat_d[s]  = dat_q[s];
      sft_d[s]  = sft_q[s];
      mode_d[s] = mode_q[s];
      if (ld[s]) begin
        vld_d[s]  = up_vld[s];
        err_d[s]  = up_vld[s] & up_err[s];
        dat_d[s]  = apply_stage(up_mode[s], up_dat[s], up_sft[s], s);
        sft_d[s]  = up_sft[s];
        mode_d[s] = up_mode[s];
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      vld_q <= '0;
      err_q <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        dat_q[s]  <= '0;
        sft_q[s]  <= '0;
        mode_q[s] <= MODE_SRL;
      end
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      for (int unsigned s = 0; s < STAGES; s++) begin
        dat_q[s]  <= dat_d[s];
        sft_q[s]  <= sft_d[s];
        mode_q[s] <= mode_d[s];
      end
    end
  end

  assign oRdy = ld[0];
  assign oVld = vld_q[STAGES-1];
  assign oDat = dat_q[STAGES-1];
  assign oErr = err_q[STAGES-1];

endmodule

// File: tb/tb_pipe_multi_type_shift.sv
// Bench for pipe_multi_type_shift (8-bit data, 4-bit shift, 2 stages): directed and random
// beats scored against an arithmetic reference model and an in-order expectation queue.
module tb_pipe_multi_type_shift;

  localparam int DW = 8;
  localparam int SW = 4;
  localparam int ST = 2;

  logic          iClk;
  logic          iRst_n;
  logic          iVld;
  logic          oRdy;
  logic [2:0]    iMode;
  logic [SW-1:0] iSftBit;
  logic [DW-1:0] iDat;
  logic          oVld;
  logic          iRdy;
  logic [DW-1:0] oDat;
  logic          oErr;

  pipe_multi_type_shift #(
    .DATA_WIDTH (DW),
    .SHIFT_WIDTH(SW),
    .STAGES     (ST)
  ) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iVld   (iVld),
    .oRdy   (oRdy),
    .iMode  (iMode),
    .iSftBit(iSftBit),
    .iDat   (iDat),
    .oVld   (oVld),
    .iRdy   (iRdy),
    .oDat   (oDat),
    .oErr   (oErr)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [7:0] dat;
    logic       err;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t exp_q[$];
  int   cons_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   stall_prev = 1'b0;

  localparam logic [2:0] T_M [9] = '{3'd1, 3'd0, 3'd2, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd3};
  localparam logic [3:0] T_N [9] = '{4'd3, 4'd3, 4'd2, 4'd1, 4'd1, 4'd9, 4'd12, 4'd8, 4'd9};
  localparam logic [7:0] T_D [9] = '{8'h90, 8'h90, 8'h0F, 8'h81, 8'h81, 8'h0F, 8'h80, 8'hFF, 8'h01};
  localparam logic [7:0] T_E [9] = '{8'hF2, 8'h12, 8'h3C, 8'h03, 8'hC0, 8'h00, 8'hFF, 8'h00, 8'h80};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference result {err, data} from plain integer arithmetic.
  function automatic logic [8:0] model(input logic [2:0] m, input logic [3:0] n, input logic [7:0] d);
    int          dd, sv, r;
    int unsigned nn, rot;
    logic        e;
    dd  = int'(d);
    nn  = n;
    rot = nn % 8;
    e   = 1'b0;
    case (m)
      3'd0: r = (nn >= 8) ? 0 : (dd >> nn);
      3'd1: begin
        sv = d[7] ? dd - 256 : dd;
        r  = (nn >= 8) ? (d[7] ? 255 : 0) : ((sv >>> nn) & 255);
      end
      3'd2: r = (nn >= 8) ? 0 : ((dd << nn) & 255);
      3'd3: r = ((dd >> rot) | (dd << (8 - rot))) & 255;
      3'd4: r = ((dd << rot) | (dd >> (8 - rot))) & 255;
      default: begin
        r = dd;
        e = 1'b1;
      end
    endcase
    return {e, r[7:0]};
  endfunction

  task automatic push_exp(input string nm, input logic [7:0] d, input logic e, input bit lat);
    exp_t x;
    x.name = nm;
    x.dat  = d;
    x.err  = e;
    x.acc  = cyc;
    x.lat  = lat;
    exp_q.push_back(x);
  endtask

  // One cycle: drive inputs after the falling edge, then score the outputs for that cycle.
  task automatic step(input string nm, input logic v, input logic [2:0] m, input logic [3:0] n,
                      input logic [7:0] d, input logic r, input logic [7:0] ed, input logic ee,
                      input bit lat, output bit acc);
    exp_t e;
    @(negedge iClk);
    iVld    = v;
    iMode   = m;
    iSftBit = n;
    iDat    = d;
    iRdy    = r;
    #1;
    if (stall_prev) check_eq("hold_vld", 32'(oVld), 32'd1);
    if (oVld) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_vld", 32'(oVld), 32'd0);
      end else begin
        check_eq({exp_q[0].name, "_dat"}, 32'(oDat), 32'(exp_q[0].dat));
        check_eq({exp_q[0].name, "_err"}, 32'(oErr), 32'(exp_q[0].err));
        if (iRdy) begin
          e = exp_q.pop_front();
          cons_q.push_back(cyc);
          if (e.lat) check_eq({e.name, "_latency"}, 32'(cyc - e.acc), 32'(ST));
        end
      end
    end
    stall_prev = oVld && !iRdy;
    acc = v && oRdy;
    if (acc) push_exp(nm, ed, ee, lat);
  endtask

  task automatic idle(input logic r);
    bit acc;
    step("idle", 1'b0, 3'd0, 4'd0, 8'd0, r, 8'd0, 1'b0, 1'b0, acc);
  endtask

  task automatic send(input string nm, input logic [2:0] m, input logic [3:0] n,
                      input logic [7:0] d, input logic [7:0] ed, input logic ee);
    bit acc;
    step(nm, 1'b1, m, n, d, 1'b1, ed, ee, 1'b1, acc);
    check_eq({nm, "_acc"}, 32'(acc), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    idle(1'b1);
    idle(1'b1);
  endtask

  initial begin
    bit         acc;
    logic [2:0] m;
    logic [3:0] n;
    logic [7:0] d, ed;
    logic       ee;

    iRst_n = 1'b0; iVld = 1'b0; iRdy = 1'b0; iMode = 3'd0; iSftBit = 4'd0; iDat = 8'd0;
    #2;
    check_eq("rst_vld", 32'(oVld), 32'd0);
    check_eq("rst_dat", 32'(oDat), 32'd0);
    check_eq("rst_err", 32'(oErr), 32'd0);
    check_eq("rst_rdy", 32'(oRdy), 32'd1);

    // Beat waiting across reset release is taken on the first rising edge afterwards.
    #9;
    iVld = 1'b1; iMode = 3'd2; iSftBit = 4'd2; iDat = 8'h0F; iRdy = 1'b1;
    #2;
    iRst_n = 1'b1;
    check_eq("rel_rdy", 32'(oRdy), 32'd1);
    push_exp("rel", 8'h3C, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 9; i++) send($sformatf("dir%0d", i), T_M[i], T_N[i], T_D[i], T_E[i], 1'b0);
    drain();

    send("illegal", 3'd7, 4'd3, 8'h5A, 8'h5A, 1'b1);
    send("after_ill", 3'd0, 4'd1, 8'h5A, 8'h2D, 1'b0);
    drain();

    for (int i = 0; i < 5; i++) send($sformatf("zero_m%0d", i), 3'(i), 4'd0, 8'hA5, 8'hA5, 1'b0);
    drain();

    // Backpressure: A and B fill the pipe, C waits until the sink opens.
    cons_q.delete();
    {ee, ed} = model(3'd2, 4'd2, 8'h11);
    step("bpA", 1'b1, 3'd2, 4'd2, 8'h11, 1'b0, ed, ee, 1'b0, acc);
    check_eq("bpA_acc", 32'(acc), 32'd1);
    {ee, ed} = model(3'd3, 4'd3, 8'h0F);
    step("bpB", 1'b1, 3'd3, 4'd3, 8'h0F, 1'b0, ed, ee, 1'b0, acc);
    check_eq("bpB_acc", 32'(acc), 32'd1);
    {ee, ed} = model(3'd1, 4'd1, 8'h84);
    for (int i = 0; i < 3; i++) begin
      step("bpC", 1'b1, 3'd1, 4'd1, 8'h84, 1'b0, ed, ee, 1'b0, acc);
      check_eq("bpC_full_rdy", 32'(acc), 32'd0);
    end
    step("bpC", 1'b1, 3'd1, 4'd1, 8'h84, 1'b1, ed, ee, 1'b0, acc);
    check_eq("bpC_acc_flow", 32'(acc), 32'd1);
    drain();
    check_eq("bp_count", 32'(cons_q.size()), 32'd3);
    if (cons_q.size() == 3) begin
      check_eq("bp_gap01", 32'(cons_q[1] - cons_q[0]), 32'd1);
      check_eq("bp_gap12", 32'(cons_q[2] - cons_q[1]), 32'd1);
    end

    for (int i = 0; i < 16; i++) begin
      m = 3'($urandom_range(0, 7));
      n = (i % 5 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      d = 8'($urandom);
      {ee, ed} = model(m, n, d);
      step($sformatf("str%0d", i), 1'b1, m, n, d, 1'b1, ed, ee, 1'b1, acc);
      check_eq("stream_acc", 32'(acc), 32'd1);
    end
    drain();

    for (int i = 0; i < 40; i++) begin
      m = 3'($urandom_range(0, 5));
      n = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      {ee, ed} = model(m, n, d);
      step($sformatf("rnd%0d", i), 1'($urandom_range(0, 9) < 7), m, n, d,
           1'($urandom_range(0, 1)), ed, ee, 1'b0, acc);
    end
    drain();

    // Two beats in flight, then a half-cycle reset pulse.
    {ee, ed} = model(3'd4, 4'd2, 8'hC3);
    step("mid0", 1'b1, 3'd4, 4'd2, 8'hC3, 1'b0, ed, ee, 1'b0, acc);
    step("mid1", 1'b1, 3'd0, 4'd5, 8'hF0, 1'b0, 8'h07, 1'b0, 1'b0, acc);
    idle(1'b0);
    #2;
    iRst_n = 1'b0;
    #1;
    check_eq("midrst_vld", 32'(oVld), 32'd0);
    check_eq("midrst_dat", 32'(oDat), 32'd0);
    check_eq("midrst_err", 32'(oErr), 32'd0);
    check_eq("midrst_rdy", 32'(oRdy), 32'd1);
    exp_q.delete();
    stall_prev = 1'b0;
    #4;
    iRst_n = 1'b1;
    {ee, ed} = model(3'd1, 4'd2, 8'hB4);
    send("fresh", 3'd1, 4'd2, 8'hB4, ed, ee);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_multi_type_shift.md
PIPE_MULTI_TYPE_SHIFT -- requirements
Module: pipe_multi_type_shift

Interface
REQ-001 Parameters SHALL be (name, default, meaning), one per line:
- DATA_WIDTH, 32, data width; power of 2, >= 4.
- SHIFT_WIDTH, 6, shift-amount width; >= clog2(DATA_WIDTH).
- STAGES, 2, pipeline register stages; 1..clog2(DATA_WIDTH).
REQ-002 Ports SHALL be (name, direction, width, meaning), one per line:
- iClk, in, 1, clock.
- iRst_n, in, 1, asynchronous active-low reset.
- iVld, in, 1, input beat valid.
- oRdy, out, 1, block accepts input this cycle.
- iMode, in, 3, shift type: 000 SRL, 001 SRA, 010 SLL, 011 ROR, 100 ROL, others illegal.
- iSftBit, in, SHIFT_WIDTH, shift amount (unsigned).
- iDat, in, DATA_WIDTH, operand.
- oVld, out, 1, output beat valid.
- iRdy, in, 1, downstream accepts output.
- oDat, out, DATA_WIDTH, result.
- oErr, out, 1, beat carried an illegal mode.
REQ-003 The block SHALL use one clock, iClk; reset iRst_n SHALL be asynchronous and active-low.
REQ-004 An illegal DATA_WIDTH, SHIFT_WIDTH or STAGES value SHALL raise $error at elaboration.

Function
REQ-005 Input handshake: a beat is accepted when iVld && oRdy are both high at a rising edge of iClk.
REQ-006 Output handshake: a beat is consumed when oVld && iRdy are both high at a rising edge of iClk.
REQ-007 Pipeline: STAGES register stages, each holding a valid bit, the partial data, the remaining shift bits, the mode and the error flag.
REQ-008 Stage advance: stage s loads when stage s+1 is empty or advancing; the last stage advances when iRdy is high.
REQ-009 oRdy SHALL equal (stage 0 empty) || (stage 0 advancing); when iRdy is held high, throughput SHALL be 1 beat per cycle.
REQ-010 Latency SHALL be exactly STAGES cycles from acceptance to oVld when there is no backpressure.
REQ-011 Ordering: beats SHALL leave in acceptance order; none dropped or duplicated; at most STAGES beats in flight.
REQ-012 Barrel structure: the L = clog2(DATA_WIDTH) log-shift levels are split across stages; stage s applies levels [s*ceil(L/STAGES), min(L,(s+1)*ceil(L/STAGES))).
REQ-013 Result per mode, with n = iSftBit:
- SRL: zero-fill right.
- SRA: sign-fill right.
- SLL: zero-fill left.
- ROR: rotate right by n mod DATA_WIDTH.
- ROL: rotate left by n mod DATA_WIDTH.
REQ-014 Over-range (n >= DATA_WIDTH) in non-rotate modes: SRL and SLL SHALL give 0; SRA SHALL give all bits equal to iDat MSB.
REQ-015 n = 0 SHALL return iDat unchanged in every legal mode.
REQ-016 Illegal mode: oDat SHALL equal iDat and oErr SHALL be 1 for that beat only; oErr SHALL be 0 for legal modes.
REQ-017 Stall hold: while oVld && !iRdy, oDat, oErr and oVld SHALL hold stable.
REQ-018 Stall and flow: the pipeline SHALL fill behind a stall, and oRdy SHALL drop only when all STAGES stages are full.
REQ-019 Simultaneous events: with a full pipe and iRdy=1, the block SHALL accept a new beat in the same cycle one leaves (oRdy=1).
REQ-020 Outputs SHALL be registered; oRdy is the only combinational output and depends only on stage state and iRdy.

Reset
REQ-021 Reset assertion: asserting iRst_n low SHALL clear all stage valid bits immediately and asynchronously; oVld=0, oErr=0, oDat=0.
REQ-022 Reset mid-operation: in-flight beats SHALL be discarded with no partial output after release.
REQ-023 Reset release: the first beat SHALL be accepted on the first rising edge after release (oRdy=1 while reset is low).

Verification (DATA_WIDTH=8, SHIFT_WIDTH=4, STAGES=2)
REQ-024 Mode check:
- SRA 0x90 by 3 -> 0xF2.
- SRL 0x90 by 3 -> 0x12.
- SLL 0x0F by 2 -> 0x3C.
- ROL 0x81 by 1 -> 0x03.
- ROR 0x81 by 1 -> 0xC0.
- Each result appears 2 cycles after acceptance.
REQ-025 Over-range:
- SLL 0x0F by 9 -> 0x00.
- SRA 0x80 by 12 -> 0xFF.
- SRL 0xFF by 8 -> 0x00.
- ROR 0x01 by 9 -> 0x80.
REQ-026 Backpressure: iRdy=0, push beats A,B,C -> oRdy=0 after A,B are held; C stalls. Raise iRdy -> outputs A,B,C in order, no gaps, oDat stable while stalled.
REQ-027 Streaming: 16 back-to-back random beats with iRdy=1 -> 16 outputs on consecutive cycles, each matching a reference model.
REQ-028 Illegal mode: iMode=3'b111 with iDat=0x5A -> oDat=0x5A, oErr=1; the next legal beat has oErr=0.
REQ-029 Reset mid-operation: 2 beats in flight, pulse iRst_n low for a half cycle -> oVld=0 immediately, no stale output; a fresh beat is processed correctly afterwards.
